// File: rtl/tree_pipe_gen.sv
// Pipelined binary decision-tree classifier, one tree level per stage.
// Optional hit counter: define TREE_HIT_CNT_EN.
module tree_pipe_gen #(
  parameter int KEY_W  = 16,
  parameter int LEVELS = 12,
  parameter int TAG_W  = 8,
  parameter int LVL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KEY_W-1:0]  key_in,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [LEVELS-1:0] index_out,
  output logic [TAG_W-1:0]  tag_out,
  output logic              valid_out,
  input  logic              ready_in,
  input  logic              cfg_we,
  input  logic [LVL_W-1:0]  cfg_level,
  input  logic [LEVELS-1:0] cfg_addr,
  input  logic [KEY_W-1:0]  cfg_data,
  output logic [31:0]       hit_cnt
);

  localparam int NODES = (1 << LEVELS) - 1;
  localparam logic [LVL_W:0] LVL_LIM = (LVL_W+1)'(LEVELS);

  // node table, levels packed breadth-first: level l at 2^l-1
  logic [KEY_W-1:0] node [0:NODES-1];

  // stage s holds a key that has taken s decisions
  logic [LEVELS:1]     vld;
  logic [KEY_W-1:0]    key_q  [1:LEVELS-1];
  logic [TAG_W-1:0]    tag_q  [1:LEVELS];
  logic [LEVELS-1:0]   path_q [1:LEVELS];
  logic [LEVELS-1:0]   dec;

  logic              advance;
  logic              wr_ok;
  logic [LEVELS-1:0] wr_base;
  logic [LEVELS-1:0] wr_idx;

  assign advance   = ready_in | ~vld[LEVELS];
  assign ready_out = advance;
  assign valid_out = vld[LEVELS];
  assign index_out = path_q[LEVELS];
  assign tag_out   = tag_q[LEVELS];

  assign wr_base = (LEVELS'(1) << cfg_level)
                 - LEVELS'(1);
  assign wr_idx  = wr_base + cfg_addr;
  assign wr_ok   = cfg_we
                 & ({1'b0, cfg_level} < LVL_LIM)
                 & ((cfg_addr >> cfg_level) == '0);

  // per-level decision; ties go right, unsigned compare
  always_comb begin
    dec    = '0;
    dec[0] = key_in >= node[0];
    for (int s = 1; s < LEVELS; s++) begin
      dec[s] = key_q[s] >=
        node[LEVELS'((1 << s) - 1) + path_q[s]];
    end
  end

  // node table: cleared by reset, one write per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NODES; i++) begin
        node[i] <= '0;
      end
    end else if (wr_ok) begin
      node[wr_idx] <= cfg_data;
    end
  end

  // stage registers, all frozen together on a stall
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int s = 1; s <= LEVELS; s++) begin
        path_q[s] <= '0;
        tag_q[s]  <= '0;
      end
      for (int s = 1; s < LEVELS; s++) begin
        key_q[s] <= '0;
      end
    end else if (advance) begin
      vld       <= {vld[LEVELS-1:1], valid_in};
      key_q[1]  <= key_in;
      tag_q[1]  <= tag_in;
      path_q[1] <= LEVELS'(dec[0]);
      for (int s = 1; s < LEVELS; s++) begin
        path_q[s+1] <= {path_q[s][LEVELS-2:0], dec[s]};
        tag_q[s+1]  <= tag_q[s];
      end
      for (int s = 1; s < LEVELS - 1; s++) begin
        key_q[s+1] <= key_q[s];
      end
    end
  end

`ifdef TREE_HIT_CNT_EN
  logic [31:0] hit_q;

  // saturating count of output transfers
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q <= '0;
    end else if (valid_out && ready_in &&
                 hit_q != 32'hFFFF_FFFF) begin
      hit_q <= hit_q + 32'd1;
    end
  end

  assign hit_cnt = hit_q;
`else
  assign hit_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_tree_pipe_gen.sv
// Self-checking bench for tree_pipe_gen, 3-level 16-bit tree.
// Reference model walks the tree from a plain threshold table.
module tb_tree_pipe_gen;

  logic        clk;
  logic        rst;
  logic [15:0] key_in;
  logic [7:0]  tag_in;
  logic        valid_in;
  logic        ready_out;
  logic [2:0]  index_out;
  logic [7:0]  tag_out;
  logic        valid_out;
  logic        ready_in;
  logic        cfg_we;
  logic [3:0]  cfg_level;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [31:0] hit_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] mnode [0:2][0:3];

  logic [15:0] pend_key[$];
  logic [7:0]  pend_tag[$];
  logic [2:0]  exp_idx[$];
  logic [7:0]  exp_tag[$];
  int          in_cyc[$];
  logic [2:0]  got_idx[$];
  logic [7:0]  got_tag[$];
  int          out_cyc[$];
  logic        log_ro[$];
  logic        log_vo[$];
  logic        log_ri[$];
  logic [2:0]  log_idx[$];
  logic [7:0]  log_tag[$];
  logic [31:0] log_hit[$];

  tree_pipe_gen #(
    .KEY_W (16),
    .LEVELS(3),
    .TAG_W (8),
    .LVL_W (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .tag_in   (tag_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .index_out(index_out),
    .tag_out  (tag_out),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .cfg_we   (cfg_we),
    .cfg_level(cfg_level),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .hit_cnt  (hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] ref_lookup(input logic [15:0] k);
    int p;
    p = 0;
    for (int l = 0; l < 3; l++) begin
      p = 2 * p + ((k >= mnode[l][p]) ? 1 : 0);
    end
    return 3'(p);
  endfunction

  task automatic model_clear();
    for (int l = 0; l < 3; l++)
      for (int p = 0; p < 4; p++)
        mnode[l][p] = 16'h0;
  endtask

  task automatic cfg_write(input int lvl, input int addr,
                           input logic [15:0] d);
    cfg_we    = 1'b1;
    cfg_level = 4'(lvl);
    cfg_addr  = 3'(addr);
    cfg_data  = d;
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
    if (lvl < 3 && addr < (1 << lvl))
      mnode[lvl][addr] = d;
  endtask

  task automatic config_tree();
    cfg_write(0, 0, 16'h8000);
    cfg_write(1, 0, 16'h4000);
    cfg_write(1, 1, 16'hC000);
    cfg_write(2, 0, 16'h2000);
    cfg_write(2, 1, 16'h6000);
    cfg_write(2, 2, 16'hA000);
    cfg_write(2, 3, 16'hE000);
  endtask

  task automatic push_case1();
    pend_key.delete();
    pend_tag.delete();
    pend_key.push_back(16'h7000); pend_tag.push_back(8'h11);
    pend_key.push_back(16'hFFFF); pend_tag.push_back(8'h22);
    pend_key.push_back(16'h0000); pend_tag.push_back(8'h33);
    pend_key.push_back(16'h8000); pend_tag.push_back(8'h44);
  endtask

  // drives pending keys and records per-cycle observations
  task automatic pump(input int ncyc, input int st_lo, input int st_hi,
                      input int rdy_pct, input int wr_c,
                      input int wl, input int wa,
                      input logic [15:0] wd);
    exp_idx.delete(); exp_tag.delete(); in_cyc.delete();
    got_idx.delete(); got_tag.delete(); out_cyc.delete();
    log_ro.delete(); log_vo.delete(); log_ri.delete();
    log_idx.delete(); log_tag.delete(); log_hit.delete();
    for (int c = 0; c < ncyc; c++) begin
      valid_in = (pend_key.size() > 0);
      key_in   = valid_in ? pend_key[0] : 16'($urandom);
      tag_in   = valid_in ? pend_tag[0] : 8'($urandom);
      if (c >= st_lo && c <= st_hi)
        ready_in = 1'b0;
      else
        ready_in = ($urandom_range(0, 99) < rdy_pct);
      cfg_we    = (c == wr_c);
      cfg_level = 4'(wl);
      cfg_addr  = 3'(wa);
      cfg_data  = wd;
      #1;
      log_ro.push_back(ready_out);
      log_vo.push_back(valid_out);
      log_ri.push_back(ready_in);
      log_idx.push_back(index_out);
      log_tag.push_back(tag_out);
      log_hit.push_back(hit_cnt);
      if (valid_in && ready_out) begin
        exp_idx.push_back(ref_lookup(pend_key[0]));
        exp_tag.push_back(pend_tag[0]);
        in_cyc.push_back(c);
        void'(pend_key.pop_front());
        void'(pend_tag.pop_front());
      end
      if (valid_out && ready_in) begin
        got_idx.push_back(index_out);
        got_tag.push_back(tag_out);
        out_cyc.push_back(c);
      end
      @(posedge clk);
      @(negedge clk);
    end
    valid_in = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ready_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_assert++;
    if (valid_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %0b expected 0", valid_out);
    end
    n_assert++;
    if (index_out !== 3'd0) begin
      n_fail++; $display("FAIL reset_index: got %0d expected 0", index_out);
    end
    n_assert++;
    if (tag_out !== 8'h0) begin
      n_fail++; $display("FAIL reset_tag: got %0h expected 0", tag_out);
    end
    n_assert++;
    if (hit_cnt !== 32'h0) begin
      n_fail++; $display("FAIL reset_hit: got %0d expected 0", hit_cnt);
    end
    n_assert++;
    if (ready_out !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %0b expected 1", ready_out);
    end
    @(negedge clk);
  endtask

  task automatic test_lookups();
    logic [2:0] e_idx [4];
    logic [7:0] e_tag [4];
    e_idx = '{3'd3, 3'd7, 3'd0, 3'd4};
    e_tag = '{8'h11, 8'h22, 8'h33, 8'h44};
    config_tree();
    push_case1();
    pump(10, -1, -2, 100, -1, 0, 0, 16'h0);
    n_assert++;
    if (got_idx.size() !== 4) begin
      n_fail++; $display("FAIL lookup_count: got %0d expected 4", got_idx.size());
    end
    for (int i = 0; i < 4 && i < got_idx.size(); i++) begin
      n_assert++;
      if (got_idx[i] !== e_idx[i]) begin
        n_fail++; $display("FAIL lookup_idx[%0d]: got %0d expected %0d", i, got_idx[i], e_idx[i]);
      end
      n_assert++;
      if (got_tag[i] !== e_tag[i]) begin
        n_fail++; $display("FAIL lookup_tag[%0d]: got %0h expected %0h", i, got_tag[i], e_tag[i]);
      end
      n_assert++;
      if (out_cyc[i] !== i + 3) begin
        n_fail++; $display("FAIL lookup_cycle[%0d]: got %0d expected %0d", i, out_cyc[i], i + 3);
      end
    end
  endtask

  task automatic test_stall();
    logic [2:0] e_idx [4];
    e_idx = '{3'd3, 3'd7, 3'd0, 3'd4};
    push_case1();
    pump(14, 3, 6, 100, -1, 0, 0, 16'h0);
    for (int c = 3; c <= 6; c++) begin
      n_assert++;
      if (log_vo[c] !== 1'b1 || log_idx[c] !== 3'd3 || log_tag[c] !== 8'h11) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got v%0b i%0d t%0h expected v1 i3 t11", c, log_vo[c], log_idx[c], log_tag[c]);
      end
      n_assert++;
      if (log_ro[c] !== 1'b0) begin
        n_fail++; $display("FAIL stall_ready[%0d]: got %0b expected 0", c, log_ro[c]);
      end
    end
    n_assert++;
    if (got_idx.size() !== 4) begin
      n_fail++; $display("FAIL stall_count: got %0d expected 4", got_idx.size());
    end
    for (int i = 0; i < 4 && i < got_idx.size(); i++) begin
      n_assert++;
      if (got_idx[i] !== e_idx[i] || out_cyc[i] !== i + 7) begin
        n_fail++; $display("FAIL stall_out[%0d]: got %0d@%0d expected %0d@%0d", i, got_idx[i], out_cyc[i], e_idx[i], i + 7);
      end
    end
  endtask

  task automatic test_collision();
    pend_key.delete(); pend_tag.delete();
    pend_key.push_back(16'h7000); pend_tag.push_back(8'hA1);
    pend_key.push_back(16'h7000); pend_tag.push_back(8'hA2);
    pump(8, -1, -2, 100, 2, 2, 1, 16'h7800);
    mnode[2][1] = 16'h7800;
    n_assert++;
    if (got_idx.size() !== 2) begin
      n_fail++; $display("FAIL collide_count: got %0d expected 2", got_idx.size());
    end else begin
      n_assert++;
      if (got_idx[0] !== 3'd3 || got_tag[0] !== 8'hA1) begin
        n_fail++; $display("FAIL collide_old: got %0d/%0h expected 3/a1", got_idx[0], got_tag[0]);
      end
      n_assert++;
      if (got_idx[1] !== 3'd2 || got_tag[1] !== 8'hA2) begin
        n_fail++; $display("FAIL collide_new: got %0d/%0h expected 2/a2", got_idx[1], got_tag[1]);
      end
    end
    cfg_write(2, 1, 16'h6000);
  endtask

  task automatic test_invalid_writes();
    logic [2:0] e_idx [4];
    e_idx = '{3'd3, 3'd7, 3'd0, 3'd4};
    cfg_write(3, 0, 16'hFFFF);
    cfg_write(1, 2, 16'h0000);
    cfg_write(0, 1, 16'hFFFF);
    cfg_write(2, 5, 16'h0000);
    cfg_write(15, 0, 16'h0000);
    push_case1();
    pump(10, -1, -2, 100, -1, 0, 0, 16'h0);
    n_assert++;
    if (got_idx.size() !== 4) begin
      n_fail++; $display("FAIL inval_count: got %0d expected 4", got_idx.size());
    end
    for (int i = 0; i < 4 && i < got_idx.size(); i++) begin
      n_assert++;
      if (got_idx[i] !== e_idx[i]) begin
        n_fail++; $display("FAIL inval_idx[%0d]: got %0d expected %0d", i, got_idx[i], e_idx[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    int sel;
    int l;
    for (int i = 0; i < 3; i++)
      for (int p = 0; p < (1 << i); p++) begin
        d = 16'($urandom);
        cfg_write(i, p, d);
      end
    pend_key.delete(); pend_tag.delete();
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 3);
      l = $urandom_range(0, 2);
      d = mnode[l][$urandom_range(0, (1 << l) - 1)];
      case (sel)
        0: d = 16'($urandom);
        1: d = d;
        2: d = d - 16'd1;
        default: d = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
      endcase
      pend_key.push_back(d);
      pend_tag.push_back(8'($urandom));
    end
    pump(220, -1, -2, 70, -1, 0, 0, 16'h0);
    n_assert++;
    if (got_idx.size() !== 60 || exp_idx.size() !== 60) begin
      n_fail++; $display("FAIL rand_count: got %0d/%0d expected 60", got_idx.size(), exp_idx.size());
    end
    for (int i = 0; i < got_idx.size() && i < exp_idx.size(); i++) begin
      n_assert++;
      if (got_idx[i] !== exp_idx[i] || got_tag[i] !== exp_tag[i]) begin
        n_fail++; $display("FAIL rand_out[%0d]: got %0d/%0h expected %0d/%0h", i, got_idx[i], got_tag[i], exp_idx[i], exp_tag[i]);
      end
    end
    for (int c = 1; c < log_vo.size(); c++) begin
      if (log_vo[c-1] && !log_ri[c-1]) begin
        n_assert++;
        if (log_vo[c] !== 1'b1 || log_idx[c] !== log_idx[c-1] || log_tag[c] !== log_tag[c-1]) begin
          n_fail++; $display("FAIL rand_stable[%0d]: got %0d/%0h expected %0d/%0h", c, log_idx[c], log_tag[c], log_idx[c-1], log_tag[c-1]);
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    push_case1();
    pump(6, 0, 100, 100, -1, 0, 0, 16'h0);
    pend_key.delete(); pend_tag.delete();
    rst = 1'b1;
    ready_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1;
    n_assert++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      n_fail++; $display("FAIL rst_flight: got v%0b r%0b expected v0 r1", valid_out, ready_out);
    end
    pump(8, -1, -2, 100, -1, 0, 0, 16'h0);
    n_assert++;
    if (got_idx.size() !== 0) begin
      n_fail++; $display("FAIL rst_stale: got %0d outputs expected 0", got_idx.size());
    end
    pend_key.push_back(16'h7000); pend_tag.push_back(8'h5A);
    pump(8, -1, -2, 100, -1, 0, 0, 16'h0);
    n_assert++;
    if (got_idx.size() !== 1) begin
      n_fail++; $display("FAIL rst_fresh_count: got %0d expected 1", got_idx.size());
    end else begin
      n_assert++;
      if (got_idx[0] !== 3'd7 || got_tag[0] !== 8'h5A) begin
        n_fail++; $display("FAIL rst_fresh: got %0d/%0h expected 7/5a", got_idx[0], got_tag[0]);
      end
    end
  endtask

  task automatic test_hit_cnt();
    logic [31:0] e_one;
    logic [31:0] e_fin;
`ifdef TREE_HIT_CNT_EN
    e_one = 32'd1;
    e_fin = 32'd5;
`else
    e_one = 32'd0;
    e_fin = 32'd0;
`endif
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    pend_key.delete(); pend_tag.delete();
    for (int n = 0; n < 5; n++) begin
      pend_key.push_back(16'($urandom));
      pend_tag.push_back(8'(n + 1));
    end
    pump(14, 3, 5, 100, -1, 0, 0, 16'h0);
    #1;
    n_assert++;
    if (got_idx.size() !== 5) begin
      n_fail++; $display("FAIL hit_transfers: got %0d expected 5", got_idx.size());
    end
    n_assert++;
    if (log_hit[5] !== 32'd0) begin
      n_fail++; $display("FAIL hit_stalled: got %0d expected 0", log_hit[5]);
    end
    n_assert++;
    if (log_hit[7] !== e_one) begin
      n_fail++; $display("FAIL hit_first: got %0d expected %0d", log_hit[7], e_one);
    end
    n_assert++;
    if (hit_cnt !== e_fin) begin
      n_fail++; $display("FAIL hit_final: got %0d expected %0d", hit_cnt, e_fin);
    end
  endtask

  initial begin
    rst       = 1'b1;
    key_in    = '0;
    tag_in    = '0;
    valid_in  = 1'b0;
    ready_in  = 1'b0;
    cfg_we    = 1'b0;
    cfg_level = '0;
    cfg_addr  = '0;
    cfg_data  = '0;
    model_clear();
    test_reset();
    test_lookups();
    test_stall();
    test_collision();
    test_invalid_writes();
    test_random();
    test_reset_inflight();
    test_hit_cnt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
